// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR constants, the controller state type and the LFSR step function.
// Build option: LFSR_PERIOD_MON_EN (used by lfsr_rand_arbiter) adds the period monitor.
package lfsr_pkg;
    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 8'hE1;
    typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;
    // Fibonacci step for x^8+x^6+x^5+x^4+1: feedback is the parity of taps 7,5,4,3.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAP_MASK)};
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or above ptr.
// Ports: req (requests), ptr (search start) -> gnt (one-hot), winner (index), found (any req).
module rr_arbiter #(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] winner,
    output logic            found
);
    int idx;
    always_comb begin
        winner = '0;
        found = 1'b0;
        idx = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                winner = ID_W'(idx);
            end
        end
        gnt = found ? N'(1) << winner : '0;
    end
endmodule

// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: one 8-bit LFSR shared round-robin between N_REQ requesters via a registered response slot.
// Ports: clk, reset (async active-low), en, seed_load/seed_val, req -> gnt,
//        rsp_valid/rsp_ready/rsp_data/rsp_id response slot, busy (LOAD state).
// Build option: LFSR_PERIOD_MON_EN adds step_cnt (saturating step count) and wrap (period pulse).
module lfsr_rand_arbiter
    import lfsr_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_SEED_DEFAULT,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [LFSR_W-1:0] rsp_data,
    output logic [ID_W-1:0]   rsp_id,
`ifdef LFSR_PERIOD_MON_EN
    output logic [15:0]       step_cnt,
    output logic              wrap,
`endif
    output logic              busy
);
    state_t state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, seed_val_q, seed_val_d, rsp_data_q, rsp_data_d, load_val;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, rsp_id_q, rsp_id_d, winner;
    logic rsp_valid_q, rsp_valid_d, grant, found;
    logic [N_REQ-1:0] arb_gnt;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req    (req),
        .ptr    (rr_ptr_q),
        .gnt    (arb_gnt),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        // reset is folded in so gnt is zero the instant reset asserts
        grant = reset && state_q == RUN && en && !seed_load && (!rsp_valid_q || rsp_ready) && found;
        gnt = grant ? arb_gnt : '0;
        load_val = seed_val_q == '0 ? SEED_DEFAULT : seed_val_q;
        state_d = seed_load ? LOAD : (en ? RUN : IDLE);
        seed_val_d = seed_load ? seed_val : seed_val_q;
        lfsr_d = state_q == LOAD ? load_val : (grant ? lfsr_next(lfsr_q) : lfsr_q);
        rsp_valid_d = grant ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_data_d = grant ? lfsr_q : rsp_data_q;
        rsp_id_d = grant ? winner : rsp_id_q;
        rr_ptr_d = grant ? (winner == ID_W'(N_REQ - 1) ? '0 : winner + 1'b1) : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED_DEFAULT;
            seed_val_q  <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            seed_val_q  <= seed_val_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = state_q == LOAD;

`ifdef LFSR_PERIOD_MON_EN
    logic [15:0] step_cnt_q, step_cnt_d;
    logic [LFSR_W-1:0] ref_q, ref_d;
    logic wrap_q, wrap_d;
    always_comb begin
        step_cnt_d = state_q == LOAD ? '0 : (grant && step_cnt_q != 16'hFFFF ? step_cnt_q + 16'd1 : step_cnt_q);
        ref_d = state_q == LOAD ? load_val : ref_q;
        // a step landing back on the last loaded value closes one full period
        wrap_d = grant && lfsr_next(lfsr_q) == ref_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt_q <= '0;
            ref_q      <= SEED_DEFAULT;
            wrap_q     <= 1'b0;
        end else begin
            step_cnt_q <= step_cnt_d;
            ref_q      <= ref_d;
            wrap_q     <= wrap_d;
        end
    end
    assign step_cnt = step_cnt_q;
    assign wrap     = wrap_q;
`endif
endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// tb_lfsr_rand_arbiter: directed self-checking bench for lfsr_rand_arbiter.
module tb_lfsr_rand_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed_val = '0;
    logic [3:0] req = '0;
    logic [3:0] gnt;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [1:0] rsp_id;
    logic       busy;
`ifdef LFSR_PERIOD_MON_EN
    logic [15:0] step_cnt;
    logic        wrap;
`endif
    int errors = 0;
    int checks = 0;

    lfsr_rand_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .req       (req),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
`ifdef LFSR_PERIOD_MON_EN
        .step_cnt  (step_cnt),
        .wrap      (wrap),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        en = 1'b0;
        seed_load = 1'b0;
        seed_val = '0;
        req = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en = 1'b1;
        req = 4'b1111;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        checks++;
        if ({rsp_valid, rsp_data, rsp_id, busy} !== 12'h000) begin
            errors++; $display("FAIL reset_outs got v=%b d=%h id=%0d busy=%b want all zero", rsp_valid, rsp_data, rsp_id, busy);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hE1; exp_b[1] = 8'hC2; exp_b[2] = 8'h85;
        do_reset();
        en = 1'b1; req = 4'b0001; rsp_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt got %b want 0000", gnt); end
        step();
        checks++;
        if (gnt !== 4'b0001 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_first_gnt got gnt=%b v=%b want 0001 0", gnt, rsp_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_b[i] || rsp_id !== 2'd0 || gnt !== 4'b0001) begin
                errors++; $display("FAIL single_byte%0d got v=%b d=%h id=%0d gnt=%b want 1 %h 0 0001", i, rsp_valid, rsp_data, rsp_id, gnt, exp_b[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        en = 1'b1; req = 4'b1111; rsp_ready = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (gnt !== 4'b0001 << (k % 4)) begin errors++; $display("FAIL rr_gnt%0d got %b want %b", k, gnt, 4'b0001 << (k % 4)); end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_id%0d got v=%b id=%0d want 1 %0d", k, rsp_valid, rsp_id, k % 4); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        en = 1'b1; req = 4'b1111; rsp_ready = 1'b1;
        step();
        step();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt_stall got %b want 0000", gnt); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'hE1 || rsp_id !== 2'd0 || gnt !== 4'b0000) begin
                errors++; $display("FAIL bp_hold%0d got v=%b d=%h id=%0d gnt=%b want 1 e1 0 0000", i, rsp_valid, rsp_data, rsp_id, gnt);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_resume_gnt got %b want 0010", gnt); end
        step();
        checks++;
        if (rsp_data !== 8'hC2 || rsp_id !== 2'd1) begin errors++; $display("FAIL bp_resume_data got d=%h id=%0d want c2 1", rsp_data, rsp_id); end
    endtask

    task automatic test_seed();
        do_reset();
        en = 1'b1; rsp_ready = 1'b1;
        step();
        seed_load = 1'b1; seed_val = 8'h00; req = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL seed_prio_gnt got %b want 0000", gnt); end
        step();
        seed_load = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || gnt !== 4'b0000) begin errors++; $display("FAIL seed_load_busy got busy=%b gnt=%b want 1 0000", busy, gnt); end
        step();
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0001) begin errors++; $display("FAIL seed_after_load got busy=%b gnt=%b want 0 0001", busy, gnt); end
        step();
        checks++;
        if (rsp_data !== 8'hE1) begin errors++; $display("FAIL seed_zero_byte got %h want e1", rsp_data); end
        seed_load = 1'b1; seed_val = 8'h01;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL seed_req_gnt got %b want 0000", gnt); end
        step();
        seed_load = 1'b0;
        step();
        step();
        checks++;
        if (rsp_data !== 8'h01) begin errors++; $display("FAIL seed01_byte0 got %h want 01", rsp_data); end
        step();
        checks++;
        if (rsp_data !== 8'h02) begin errors++; $display("FAIL seed01_byte1 got %h want 02", rsp_data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; req = 4'b1111; rsp_ready = 1'b1;
        step();
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL async_reset got v=%b gnt=%b want 0 0000", rsp_valid, gnt); end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL async_restart_gnt got %b want 0001", gnt); end
        step();
        checks++;
        if (rsp_data !== 8'hE1 || rsp_id !== 2'd0) begin errors++; $display("FAIL async_restart_data got d=%h id=%0d want e1 0", rsp_data, rsp_id); end
    endtask

`ifdef LFSR_PERIOD_MON_EN
    task automatic test_period_mon();
        int wraps;
        wraps = 0;
        do_reset();
        en = 1'b1; req = 4'b0001; rsp_ready = 1'b1;
        step();
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i < 255 && wrap === 1'b1) wraps++;
            if (i == 255) begin
                checks++;
                if (wrap !== 1'b1 || step_cnt !== 16'd255 || wraps != 0) begin
                    errors++; $display("FAIL mon_wrap got wrap=%b cnt=%0d early=%0d want 1 255 0", wrap, step_cnt, wraps);
                end
            end
        end
        checks++;
        if (rsp_data !== 8'hE1 || wrap !== 1'b0 || step_cnt !== 16'd256) begin
            errors++; $display("FAIL mon_256th got d=%h wrap=%b cnt=%0d want e1 0 256", rsp_data, wrap, step_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_seed();
        test_async_reset();
`ifdef LFSR_PERIOD_MON_EN
        test_period_mon();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
- Shares one 8-bit maximal-length Fibonacci LFSR between N_REQ requesters.
- A round-robin arbiter grants one requester per cycle. The granted requester receives the current LFSR byte through a single registered response slot, and the LFSR advances exactly one step per grant.
- Provides enable gating and runtime seed loading with lock-up protection.
- Sits between the pseudo-random generator and its consumers (test-pattern, scrambler and backoff logic).

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SEED_DEFAULT, 8'hE1, LFSR value after reset; substitute seed whenever a zero seed is loaded. Must be non-zero.
- ID_W, $clog2(N_REQ), localparam; width of rsp_id.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  service enable; when 0 no grants are issued.
- seed_load  in  1  single-cycle pulse requesting a seed load.
- seed_val  in  8  seed value sampled while seed_load=1.
- req  in  N_REQ  per-requester request level; held until the matching gnt bit is seen.
- gnt  out  N_REQ  combinational one-hot grant; the request is accepted in this cycle.
- rsp_valid  out  1  response slot holds data.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  8  random byte delivered.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- busy  out  1  high in LOAD state.

Behaviour:
- Reset (reset=0, asynchronous):
  - lfsr=SEED_DEFAULT, rr_ptr=0, state=IDLE.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - gnt=0 while reset is asserted.
- LFSR step, polynomial x^8+x^6+x^5+x^4+1:
  - next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Period is 255; the value 0 is never reached from a non-zero state.
- States:
  - IDLE: entered from reset, or from LOAD/RUN when en=0. Goes to RUN when en=1.
  - RUN: grants are issued. Goes to IDLE when en=0.
  - LOAD: lasts one cycle. lfsr <= (seed_val_q==0 ? SEED_DEFAULT : seed_val_q). Then goes to RUN if en=1, otherwise IDLE.
- seed_load=1 in any state:
  - seed_val is registered into seed_val_q and the next state is LOAD.
  - No grant is issued in that cycle or in the LOAD cycle.
  - seed_load has priority over en and over req.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Grant condition: state=RUN && en && !seed_load && slot_free && |req.
- Winner selection: the first set req bit scanning upward from rr_ptr, wrapping at N_REQ-1 back to 0.
- On grant (same edge):
  - rsp_data <= lfsr, rsp_id <= winner, rsp_valid <= 1.
  - lfsr <= next.
  - rr_ptr <= (winner==N_REQ-1) ? 0 : winner+1.
- rsp_valid && rsp_ready with no new grant: rsp_valid <= 0. rsp_data and rsp_id hold their last values.
- Back-to-back throughput: with rsp_ready held at 1, one grant per cycle, no bubbles.
- Backpressure: rsp_valid=1 && rsp_ready=0 means no grant. lfsr, rsp_data, rsp_id and rr_ptr all hold.
- en falling while rsp_valid=1: the pending response is still delivered. Only new grants stop.
- Latency: data granted in cycle t appears on rsp_data at t+1.
- Requester protocol: req may drop in the cycle after its gnt. If req is still held, the requester is treated as requesting again.

Optional Feature:
- Macro: LFSR_PERIOD_MON_EN.
- When defined, two extra outputs are added:
  - step_cnt (out, 16): counts LFSR steps. Cleared by reset and by LOAD. Saturates at 16'hFFFF.
  - wrap (out, 1): one-cycle registered pulse when a step returns lfsr to the value loaded at the last reset or LOAD, i.e. after every 255 steps.
- When undefined, neither port nor its logic exists. Core behaviour is identical either way.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR_W=8.
  - LFSR_TAP_MASK=8'hB8 (bits 7,5,4,3).
  - LFSR_SEED_DEFAULT=8'hE1.
  - State enum {IDLE, RUN, LOAD}.
  - Function lfsr_next(8-bit).
- Sub-module rr_arbiter (req, rr_ptr -> one-hot gnt, winner index) is purely combinational. It is reused by other shared-resource controllers.

Test Plan:
- Reset then en=1, req=4'b0001, rsp_ready=1 → gnt=0001 each cycle; rsp_data sequence E1, C2, 85; rsp_id=0; rsp_valid first high one cycle after en.
- req=4'b1111 held, rsp_ready=1 → rsp_id sequence 0, 1, 2, 3, 0, with one grant per cycle.
- After first response, rsp_ready=0 for 3 cycles with req=1111 → gnt=0, rsp_data stable at E1; on rsp_ready=1 the next grant delivers C2 to id 1.
- seed_load=1, seed_val=8'h00 → busy for one cycle, next delivered byte E1. seed_val=8'h01 → next bytes 01, 02. seed_load together with req → no gnt that cycle.
- reset=0 asserted mid-stream (asynchronously, between edges) → rsp_valid=0 and gnt=0 immediately. After release, the first byte is E1 and priority restarts at requester 0.
- With LFSR_PERIOD_MON_EN defined: 255 consecutive grants → wrap pulses once on the 255th step, step_cnt=255, and the 256th byte delivered equals E1.
